livelock_watchdog: RTL and testbench

//   Monitors a small state vector and detects livelock: endless change without progress,
//   or period-2 oscillation.

---
 rtl/livelock_watchdog.sv | 158 +++++++++++++++
 tb/tb_livelock_watchdog.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/livelock_watchdog.sv
// rtl/livelock_watchdog.sv - livelock detector: change-without-progress and period-2 oscillation
module livelock_watchdog #(
   parameter int WIDTH   = 3,
   parameter int LIMIT   = 16,
   parameter int OSC_MIN = 4,
   parameter int CW      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clear,
   input  logic             progress,
   input  logic [WIDTH-1:0] sig,
   output logic             armed,
   output logic             trip,
   output logic [1:0]       trip_cause,
   output logic [WIDTH-1:0] snap,
   output logic [CW-1:0]    cyc_count
);

   // Counters only need to reach their trip thresholds, never beyond.
   localparam int CCW = $clog2(LIMIT + 1);
   localparam int OCW = $clog2(OSC_MIN + 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_TRIPPED = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] prev1_q, prev1_d;
   logic [WIDTH-1:0] prev2_q, prev2_d;
   logic [CCW-1:0]   chg_cnt_q, chg_cnt_d;
   logic [OCW-1:0]   osc_cnt_q, osc_cnt_d;
   logic             trip_q, trip_d;
   logic [1:0]       cause_q, cause_d;
   logic [WIDTH-1:0] snap_q, snap_d;
   logic [CW-1:0]    cyc_q, cyc_d;

   logic             chg;
   logic             osc2;
   logic [CCW-1:0]   chg_inc;
   logic [OCW-1:0]   osc_inc;
   logic             hit_c;
   logic             hit_o;

   // Next-state and per-sample detection; clear wins over any same-cycle trip.
   always_comb begin
      state_d   = state_q;
      prev1_d   = prev1_q;
      prev2_d   = prev2_q;
      chg_cnt_d = chg_cnt_q;
      osc_cnt_d = osc_cnt_q;
      trip_d    = trip_q;
      cause_d   = cause_q;
      snap_d    = snap_q;
      cyc_d     = cyc_q;

      chg     = (sig != prev1_q);
      osc2    = chg && (sig == prev2_q);
      chg_inc = chg_cnt_q + CCW'(1);
      osc_inc = osc_cnt_q + OCW'(1);
      hit_c   = !progress && chg && (chg_inc == CCW'(LIMIT));
      hit_o   = !progress && osc2 && (osc_inc == OCW'(OSC_MIN));

      case (state_q)
         ST_IDLE: begin
            if (en && !clear) begin
               prev1_d   = sig;
               prev2_d   = sig;
               chg_cnt_d = '0;
               osc_cnt_d = '0;
               cyc_d     = '0;
               state_d   = ST_ARMED;
            end
         end
         ST_ARMED: begin
            if (clear) begin
               state_d   = ST_IDLE;
               prev1_d   = '0;
               prev2_d   = '0;
               chg_cnt_d = '0;
               osc_cnt_d = '0;
               trip_d    = 1'b0;
               cause_d   = 2'b00;
               snap_d    = '0;
               cyc_d     = '0;
            end else if (en) begin
               prev2_d = prev1_q;
               prev1_d = sig;
               cyc_d   = (&cyc_q) ? cyc_q : cyc_q + CW'(1);

               if (progress || !chg) chg_cnt_d = '0;
               else                  chg_cnt_d = chg_inc;

               if (progress || !osc2) osc_cnt_d = '0;
               else                   osc_cnt_d = osc_inc;

               if (hit_c || hit_o) begin
                  state_d = ST_TRIPPED;
                  trip_d  = 1'b1;
                  cause_d = {hit_o, hit_c};
                  snap_d  = sig;
               end
            end
         end
         ST_TRIPPED: begin
            if (clear) begin
               state_d   = ST_IDLE;
               prev1_d   = '0;
               prev2_d   = '0;
               chg_cnt_d = '0;
               osc_cnt_d = '0;
               trip_d    = 1'b0;
               cause_d   = 2'b00;
               snap_d    = '0;
               cyc_d     = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         prev1_q   <= '0;
         prev2_q   <= '0;
         chg_cnt_q <= '0;
         osc_cnt_q <= '0;
         trip_q    <= 1'b0;
         cause_q   <= 2'b00;
         snap_q    <= '0;
         cyc_q     <= '0;
      end else begin
         state_q   <= state_d;
         prev1_q   <= prev1_d;
         prev2_q   <= prev2_d;
         chg_cnt_q <= chg_cnt_d;
         osc_cnt_q <= osc_cnt_d;
         trip_q    <= trip_d;
         cause_q   <= cause_d;
         snap_q    <= snap_d;
         cyc_q     <= cyc_d;
      end
   end

   assign armed      = (state_q == ST_ARMED);
   assign trip       = trip_q;
   assign trip_cause = cause_q;
   assign snap       = snap_q;
   assign cyc_count  = cyc_q;

endmodule

// File: tb/tb_livelock_watchdog.sv
// tb/tb_livelock_watchdog.sv - scoreboard bench for livelock_watchdog against a history-based model
module tb_livelock_watchdog;

   localparam int WIDTH   = 3;
   localparam int LIMIT   = 16;
   localparam int OSC_MIN = 4;
   localparam int CW      = 8;

   logic             clk;
   logic             rst;
   logic             en;
   logic             clear;
   logic             progress;
   logic [WIDTH-1:0] sig;
   logic             armed;
   logic             trip;
   logic [1:0]       trip_cause;
   logic [WIDTH-1:0] snap;
   logic [CW-1:0]    cyc_count;

   livelock_watchdog #(
      .WIDTH  (WIDTH),
      .LIMIT  (LIMIT),
      .OSC_MIN(OSC_MIN),
      .CW     (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .clear     (clear),
      .progress  (progress),
      .sig       (sig),
      .armed     (armed),
      .trip      (trip),
      .trip_cause(trip_cause),
      .snap      (snap),
      .cyc_count (cyc_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic             armed;
      logic             trip;
      logic [1:0]       cause;
      logic [WIDTH-1:0] snap;
      logic [CW-1:0]    cyc;
   } obs_t;

   obs_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: full sample history since arming, runs found by scanning back.
   int               m_state = 0;   // 0 idle, 1 armed, 2 tripped
   logic             m_trip  = 1'b0;
   logic [1:0]       m_cause = 2'b00;
   logic [WIDTH-1:0] m_snap  = '0;
   int               m_cyc   = 0;
   logic [WIDTH-1:0] hist[$];
   bit               prog_hist[$];

   function automatic int run_len(bit osc_mode);
      int n = 0;
      for (int j = hist.size() - 1; j >= 2; j--) begin
         bit c = (hist[j] != hist[j-1]);
         bit o = c && (hist[j] == hist[j-2]);
         if (prog_hist[j] || !(osc_mode ? o : c)) break;
         n++;
         if (n > LIMIT + OSC_MIN) break;
      end
      return n;
   endfunction

   task automatic model_zero();
      m_state = 0;
      m_trip  = 1'b0;
      m_cause = 2'b00;
      m_snap  = '0;
      m_cyc   = 0;
   endtask

   task automatic step(input bit r, input bit e, input bit c, input bit p,
                       input logic [WIDTH-1:0] s);
      obs_t o;
      rst = r; en = e; clear = c; progress = p; sig = s;
      if (r) begin
         model_zero();
      end else if (m_state == 0) begin
         if (e && !c) begin
            hist.delete(); prog_hist.delete();
            hist.push_back(s); hist.push_back(s);
            prog_hist.push_back(1'b0); prog_hist.push_back(1'b0);
            m_cyc   = 0;
            m_state = 1;
         end
      end else if (c) begin
         model_zero();
      end else if (m_state == 1 && e) begin
         int cr, orr;
         hist.push_back(s);
         prog_hist.push_back(p);
         if (m_cyc < (1 << CW) - 1) m_cyc++;
         cr  = run_len(1'b0);
         orr = run_len(1'b1);
         if (cr == LIMIT || orr == OSC_MIN) begin
            m_state = 2;
            m_trip  = 1'b1;
            m_cause = {orr == OSC_MIN, cr == LIMIT};
            m_snap  = s;
         end
      end
      o.armed = (m_state == 1);
      o.trip  = m_trip;
      o.cause = m_cause;
      o.snap  = m_snap;
      o.cyc   = CW'(m_cyc);
      exp_q.push_back(o);
      @(negedge clk);
   endtask

   // Monitor: after every edge, pop the expected observation and compare.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         obs_t e;
         obs_t g;
         e = exp_q.pop_front();
         g = {armed, trip, trip_cause, snap, cyc_count};
         checks++;
         if (g !== e) begin
            errors++;
            $display("FAIL obs t=%0t got armed=%0d trip=%0d cause=%0d snap=%0d cyc=%0d required armed=%0d trip=%0d cause=%0d snap=%0d cyc=%0d",
                     $time, g.armed, g.trip, g.cause, g.snap, g.cyc,
                     e.armed, e.trip, e.cause, e.snap, e.cyc);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s got %0d required %0d", name, got, req);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_armed"}, 32'(armed), 32'd0);
      chk({tag, "_trip"},  32'(trip), 32'd0);
      chk({tag, "_cause"}, 32'(trip_cause), 32'd0);
      chk({tag, "_snap"},  32'(snap), 32'd0);
      chk({tag, "_cyc"},   32'(cyc_count), 32'd0);
   endtask

   task automatic do_clear();
      step(0, 0, 1, 0, '0);
   endtask

   initial begin
      logic [WIDTH-1:0] ls1, ls2, nv;
      rst = 1'b1; en = 1'b0; clear = 1'b0; progress = 1'b0; sig = '0;
      @(negedge clk);
      step(1, 0, 0, 0, '0);
      step(1, 1, 0, 0, 3'd5);
      chk_zero("reset");

      // T1: oscillation
      step(0, 1, 0, 0, 3'b010);
      for (int k = 1; k <= 5; k++) step(0, 1, 0, 0, (k % 2) ? 3'b001 : 3'b010);
      chk("t1_trip", 32'(trip), 32'd1);
      chk("t1_cause", 32'(trip_cause), 32'd2);
      chk("t1_snap", 32'(snap), 32'd1);
      chk("t1_cyc", 32'(cyc_count), 32'd5);
      chk("t1_armed", 32'(armed), 32'd0);
      step(0, 1, 0, 1, 3'b111);
      chk("t1_frozen_cyc", 32'(cyc_count), 32'd5);
      do_clear();

      // T2: change limit
      step(0, 1, 0, 0, 3'd0);
      for (int k = 1; k <= 16; k++) begin
         step(0, 1, 0, 0, 3'(k % 8));
         if (k == 15) chk("t2_no_trip_at_15", 32'(trip), 32'd0);
      end
      chk("t2_trip", 32'(trip), 32'd1);
      chk("t2_cause", 32'(trip_cause), 32'd1);
      chk("t2_snap", 32'(snap), 32'd0);
      chk("t2_cyc", 32'(cyc_count), 32'd16);
      do_clear();

      // T3: periodic progress prevents trip
      step(0, 1, 0, 0, 3'd0);
      for (int k = 1; k <= 100; k++) step(0, 1, 0, (k % 10) == 0, 3'(k % 8));
      chk("t3_trip", 32'(trip), 32'd0);
      chk("t3_armed", 32'(armed), 32'd1);
      chk("t3_cyc", 32'(cyc_count), 32'd100);
      do_clear();

      // T4: pause then clear
      step(0, 1, 0, 0, 3'b010);
      step(0, 1, 0, 0, 3'b001);
      step(0, 1, 0, 0, 3'b010);
      for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 3'($urandom_range(0, 7)));
      chk("t4_no_trip_in_pause", 32'(trip), 32'd0);
      step(0, 1, 0, 0, 3'b001);
      step(0, 1, 0, 0, 3'b010);
      chk("t4_no_trip_early", 32'(trip), 32'd0);
      step(0, 1, 0, 0, 3'b001);
      chk("t4_trip", 32'(trip), 32'd1);
      chk("t4_cyc", 32'(cyc_count), 32'd5);
      do_clear();
      chk_zero("t4_clear");

      // T5A: reset mid-run
      step(0, 1, 0, 0, 3'd0);
      for (int k = 1; k <= 10; k++) step(0, 1, 0, 0, 3'(k % 8));
      step(1, 1, 0, 0, 3'd3);
      chk_zero("t5a");

      // T5B: clear on the trip cycle
      step(0, 1, 0, 0, 3'b010);
      for (int k = 1; k <= 4; k++) step(0, 1, 0, 0, (k % 2) ? 3'b001 : 3'b010);
      step(0, 1, 1, 0, 3'b001);
      chk_zero("t5b");
      step(0, 0, 0, 0, 3'b010);
      chk("t5b_still_idle_trip", 32'(trip), 32'd0);

      // cyc_count saturation
      step(0, 1, 0, 0, 3'd0);
      for (int k = 1; k <= 300; k++) step(0, 1, 0, (k % 10) == 0, 3'(k % 8));
      chk("sat_cyc", 32'(cyc_count), 32'd255);
      chk("sat_armed", 32'(armed), 32'd1);
      do_clear();

      // Randomized traffic
      ls1 = '0; ls2 = '0;
      for (int k = 0; k < 1500; k++) begin
         case ($urandom_range(0, 3))
            0: nv = ls2;
            1: nv = ls1 + 3'd1;
            2: nv = ls1;
            default: nv = 3'($urandom_range(0, 7));
         endcase
         step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 85,
              $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 8, nv);
         ls2 = ls1;
         ls1 = nv;
      end
      do_clear();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
